// File: rtl/mac_accumulator_16bit.sv
// Sequential unsigned multiply-accumulate element: shift-add multiplier feeding a
// 16-bit carry-lookahead accumulator, with valid/ready operand input and result output.

module carry_lookaheadadder_16bit (
  input  logic [15:0] inData_A,
  input  logic [15:0] inData_B,
  input  logic        cin,
  output logic [15:0] outData,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = inData_A & inData_B;
  assign p = inData_A ^ inData_B;

  // Two-level lookahead: 4-bit groups, then group carries from group G/P.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign gp[k] = &p[4*k +: 4];
    assign c[4*k]   = gc[k];
    assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
    assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
    assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
  end

  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign outData = p ^ c;
  assign cout    = gc[4];
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready; valid never
// waits on ready, and the producer holds data while valid && !ready.
module mac_accumulator_16bit #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   inData_A,
  input  logic [DATA_WIDTH-1:0]   inData_B,
  input  logic                    inValid,
  output logic                    inReady,
  output logic [2*DATA_WIDTH-1:0] outData,
  output logic                    outOvf,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [1:0]              dbg_state
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int EW = $clog2(VEC_LEN + 1);

  typedef enum logic [1:0] {IDLE, MULT, ACCUM, DONE} state_t;

  state_t                state;
  logic [PW-1:0]         acc, product, mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [BW-1:0]         bitCnt;
  logic [EW-1:0]         elemCnt;
  logic                  ovf;
  logic [15:0]           sum;
  logic                  carry;

  carry_lookaheadadder_16bit u_add (
    .inData_A (acc),
    .inData_B (product),
    .cin      (1'b0),
    .outData  (sum),
    .cout     (carry)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      product  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      bitCnt   <= '0;
      elemCnt  <= '0;
      ovf      <= 1'b0;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      outData  <= '0;
      outOvf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          inReady <= 1'b1;
          if (inValid && inReady) begin
            mcand   <= {{DATA_WIDTH{1'b0}}, inData_A};
            mplier  <= inData_B;
            product <= '0;
            bitCnt  <= '0;
            inReady <= 1'b0;
            state   <= MULT;
          end
        end
        MULT: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          bitCnt <= bitCnt + BW'(1);
          if (bitCnt == BW'(DATA_WIDTH - 1)) state <= ACCUM;
        end
        ACCUM: begin
          acc     <= sum;
          ovf     <= ovf | carry;
          elemCnt <= elemCnt + EW'(1);
          if (elemCnt == EW'(VEC_LEN - 1)) begin
            state    <= DONE;
            outValid <= 1'b1;
            outData  <= sum;
            outOvf   <= ovf | carry;
          end else begin
            state   <= IDLE;
            inReady <= 1'b1;
          end
        end
        DONE: begin
          // Result stays registered until taken; clearing here starts the next sum from 0.
          if (outReady) begin
            acc      <= '0;
            ovf      <= 1'b0;
            elemCnt  <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outOvf   <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
